// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side byte streams and UART core handshake bundle
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      uart_ready;
  logic                      uart_done;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic                      grant_valid;
  logic [2:0]                grant_id;
  logic                      burst_end;
  modport master (
    output req_valid, req_data, req_last, uart_ready, uart_done,
    input  req_ready, tx_start, tx_data, grant_valid, grant_id, burst_end
  );
  modport slave (
    input  req_valid, req_data, req_last, uart_ready, uart_done,
    output req_ready, tx_start, tx_data, grant_valid, grant_id, burst_end
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, burst-locked sharing of one UART transmit engine
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input logic clk,
  input logic rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [7:0] MAXB = 8'(MAX_BURST);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, START = 2'd2, WAIT = 2'd3;
  logic [1:0] state_q, state_d;
  logic [IW-1:0] gid_q, gid_d, last_q, last_d, pick;
  logic [7:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d, sel_data;
  logic gv_q, gv_d, be_q, be_d, lf_q, lf_d;
  logic any_req, sel_valid, sel_last, rel;
  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
    return IW'((int'(base) + 1 + k) % NUM_REQ);
  endfunction
  // descending scan so the channel closest after last_q wins
  always_comb begin
    pick = '0;
    any_req = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[rr_idx(last_q, k)]) begin
        pick = rr_idx(last_q, k);
        any_req = 1'b1;
      end
    end
  end
  assign sel_valid = bus.req_valid[gid_q];
  assign sel_last  = bus.req_last[gid_q];
  assign sel_data  = bus.req_data[int'(gid_q)*DATA_W +: DATA_W];
  assign bus.req_ready = (state_q == LOAD && bus.uart_ready && sel_valid) ? NUM_REQ'(1) << gid_q : '0;
  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    last_d  = last_q;
    gv_d    = gv_q;
    be_d    = 1'b0;
    lf_d    = lf_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rel     = 1'b0;
    case (state_q)
      IDLE: if (any_req) begin
        gid_d   = pick;
        gv_d    = 1'b1;
        cnt_d   = '0;
        state_d = LOAD;
      end
      LOAD: if (!sel_valid) rel = 1'b1;
      else if (bus.uart_ready) begin
        data_d  = sel_data;
        lf_d    = sel_last;
        cnt_d   = cnt_q == MAXB ? cnt_q : cnt_q + 8'd1;
        state_d = START;
      end
      START: state_d = WAIT;
      default: if (bus.uart_done) begin
        rel     = lf_q || cnt_q == MAXB;
        state_d = LOAD;
      end
    endcase
    if (rel) begin
      gv_d    = 1'b0;
      last_d  = gid_q;
      be_d    = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gid_q   <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      gv_q    <= 1'b0;
      be_q    <= 1'b0;
      lf_q    <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      gv_q    <= gv_d;
      be_q    <= be_d;
      lf_q    <= lf_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end
  assign bus.tx_start    = state_q == START;
  assign bus.tx_data     = data_q;
  assign bus.grant_valid = gv_q;
  assign bus.grant_id    = 3'(gid_q);
  assign bus.burst_end   = be_q;
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit engine between NUM_REQ byte-stream requesters.
- Round-robin arbitration with burst locking: a granted requester keeps the engine until it flags its last byte, hits MAX_BURST bytes, or drops valid.
- Sits between peripheral/bus-side byte sources and the UART core, and drives the core's start/data/done handshake.

Parameters:
NUM_REQ, 4, number of requester channels (2..8)
DATA_W, 8, byte width carried to UART
MAX_BURST, 16, maximum bytes per grant before forced re-arbitration (1..255)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester byte available
req_data  in  NUM_REQ*DATA_W  per-requester byte; channel i at [i*DATA_W +: DATA_W]
req_last  in  NUM_REQ  byte on channel i is last of burst
req_ready  out  NUM_REQ  byte accepted from channel i this cycle (combinational)
uart_ready  in  1  UART engine idle, can accept tx_start
uart_done  in  1  one-cycle pulse: current byte fully shifted out, stop bits included
tx_start  out  1  one-cycle pulse to UART: latch tx_data
tx_data  out  DATA_W  byte to transmit, held stable from tx_start until uart_done
grant_valid  out  1  a channel currently owns the engine
grant_id  out  3  index of owning channel; valid only when grant_valid=1
burst_end  out  1  one-cycle pulse when a grant is released

Behaviour:
- Reset values: req_ready=0, tx_start=0, tx_data=0, grant_valid=0, grant_id=0, burst_end=0, byte count=0, last-grant pointer=NUM_REQ-1, state=IDLE. Any in-flight burst is abandoned. Reset never pulses tx_start.
- FSM states: IDLE, LOAD, START, WAIT.
- IDLE:
  - If any req_valid, choose the first asserted channel scanning from (last_grant+1) mod NUM_REQ upward with wrap.
  - Register grant_id, set grant_valid=1, clear byte count, go to LOAD. Latency from req_valid to grant_valid is 1 cycle.
  - With no requests, stay in IDLE.
- LOAD:
  - req_ready[g] = (state==LOAD) & uart_ready & req_valid[g]. All other req_ready bits are 0.
  - On transfer: capture req_data[g] into tx_data, capture req_last[g] into last_flag, increment the byte count, go to START.
  - If req_valid[g]=0, release the grant and go to IDLE.
  - If uart_ready=0, hold in LOAD.
- START: tx_start=1 for exactly this one cycle; go to WAIT.
- WAIT:
  - Hold tx_data stable and wait for uart_done.
  - On uart_done: if last_flag=1 or byte count==MAX_BURST, release; else go to LOAD.
- Release: grant_valid=0, last_grant<=grant_id, burst_end=1 for one cycle, go to IDLE. A new grant can follow no earlier than the next cycle, so there is at least one IDLE cycle between bursts.
- uart_done in IDLE, LOAD or START is ignored.
- Minimum per-byte overhead is 3 cycles plus UART shift time.
- Byte counter is 8 bits and saturates at MAX_BURST. Reaching MAX_BURST forces release even if last_flag=0; the channel then competes again in round-robin.
- Simultaneous events:
  - The requester that just released has lowest priority in the next arbitration.
  - req_last together with the MAX_BURST boundary causes a single release and a single burst_end.
- Changes on req_data/req_last while req_ready=0 are ignored.

Test Plan:
- Single channel: ch2 sends 3 bytes 0xA1,0xA2,0xA3 (last on 0xA3); UART model done 20 cycles after each start -> 3 tx_start pulses carrying those values in order, grant_id=2 throughout, one burst_end after the third uart_done.
- Round-robin: ch0..ch3 all valid, each sending single-byte bursts (last=1), starting from reset -> grant order 0,1,2,3,0; never two consecutive grants to the same channel while others wait.
- Burst cap: MAX_BURST=4, ch1 streams 10 bytes with last never set, ch3 also valid -> after 4 bytes ch1 is released, ch3 granted next, then ch1 resumes with byte 5.
- Valid drop: ch0 granted, sends 2 bytes, then deasserts valid while in LOAD -> release with no tx_start, burst_end pulse, back to IDLE.
- Backpressure and spurious done: uart_ready held 0 for 50 cycles in LOAD -> req_ready stays 0 and no tx_start; a uart_done pulse injected in LOAD -> no state change.
- Reset mid-burst: assert rst during WAIT -> next cycle all outputs at reset values; after rst deasserts, ch0 (valid) is granted first.
